// File: rtl/slc_phase_timer.sv
// slc_phase_timer: two-way traffic-light phase sequencer with a time-multiplexed two-digit BCD countdown.
// Optional feature: define SLC_NIGHT_FLASH_EN to add the 'night' input (flashing yellow, display blanked).
module slc_phase_timer #(
  parameter int NS_GREEN_T = 25,
  parameter int EW_GREEN_T = 20,
  parameter int YELLOW_T   = 3,
  parameter int TICK_DIV   = 1000,
  parameter int SCAN_DIV   = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
`ifdef SLC_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [1:0] phase,
  output logic [3:0] bcd,
  output logic [2:0] dig_sel,
  output logic       blank_n
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  localparam logic [1:0] PH_NS_GREEN  = 2'd0;
  localparam logic [1:0] PH_NS_YELLOW = 2'd1;
  localparam logic [1:0] PH_EW_GREEN  = 2'd2;
  localparam logic [1:0] PH_EW_YELLOW = 2'd3;

  function automatic logic [7:0] to_bcd(input int t);
    return {4'(t / 10), 4'(t % 10)};
  endfunction

  localparam logic [7:0] NS_BCD = to_bcd(NS_GREEN_T);
  localparam logic [7:0] EW_BCD = to_bcd(EW_GREEN_T);
  localparam logic [7:0] Y_BCD  = to_bcd(YELLOW_T);

  logic [1:0]        phase_q;
  logic [3:0]        tens_q;
  logic [3:0]        ones_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic              digit_q;
  logic              tick;
  logic [7:0]        next_bcd;
  logic              night_act;
  logic              night_exit;
  logic              flash_q;

`ifdef SLC_NIGHT_FLASH_EN
  logic night_q;

  // Leaving night mode is detected one cycle late so the reload lands on the first night=0 edge.
  assign night_act  = night;
  assign night_exit = night_q && !night;

  always_ff @(posedge clk) begin
    if (clr) begin
      night_q <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      night_q <= night;
      if (night_exit)
        flash_q <= 1'b0;
      else if (night && tick)
        flash_q <= ~flash_q;
    end
  end
`else
  assign night_act  = 1'b0;
  assign night_exit = 1'b0;
  assign flash_q    = 1'b0;
`endif

  assign tick = (en || night_act) && (tick_cnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (clr || night_exit)
      tick_cnt <= '0;
    else if (en || night_act)
      tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
  end

  always_comb begin
    next_bcd = NS_BCD;
    case (phase_q)
      PH_NS_GREEN:  next_bcd = Y_BCD;
      PH_NS_YELLOW: next_bcd = EW_BCD;
      PH_EW_GREEN:  next_bcd = Y_BCD;
      PH_EW_YELLOW: next_bcd = NS_BCD;
      default:      next_bcd = NS_BCD;
    endcase
  end

  // Count runs T..1 per phase; the tick that would show 00 instead loads the next phase.
  always_ff @(posedge clk) begin
    if (clr || night_exit) begin
      phase_q <= PH_NS_GREEN;
      tens_q  <= NS_BCD[7:4];
      ones_q  <= NS_BCD[3:0];
    end else if (tick && !night_act) begin
      if (tens_q == 4'd0 && ones_q == 4'd1) begin
        phase_q <= phase_q + 2'd1;
        tens_q  <= next_bcd[7:4];
        ones_q  <= next_bcd[3:0];
      end else if (ones_q == 4'd0) begin
        ones_q <= 4'd9;
        tens_q <= tens_q - 4'd1;
      end else begin
        ones_q <= ones_q - 4'd1;
      end
    end
  end

  // Display scan is free-running and only clr stops it.
  always_ff @(posedge clk) begin
    if (clr) begin
      scan_cnt <= '0;
      digit_q  <= 1'b0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      digit_q  <= ~digit_q;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    case (phase_q)
      PH_NS_GREEN:  begin ns_light = 3'b001; ew_light = 3'b100; end
      PH_NS_YELLOW: begin ns_light = 3'b010; ew_light = 3'b100; end
      PH_EW_GREEN:  begin ns_light = 3'b100; ew_light = 3'b001; end
      PH_EW_YELLOW: begin ns_light = 3'b100; ew_light = 3'b010; end
      default:      begin ns_light = 3'b100; ew_light = 3'b100; end
    endcase
    if (night_act) begin
      ns_light = {1'b0, flash_q, 1'b0};
      ew_light = {1'b0, flash_q, 1'b0};
    end
  end

  assign phase   = phase_q;
  assign dig_sel = {2'b00, digit_q};
  assign bcd     = digit_q ? tens_q : ones_q;
  assign blank_n = !(digit_q && (tens_q == 4'd0)) && !night_act;

endmodule

// File: tb/tb_slc_phase_timer.sv
// tb_slc_phase_timer: directed vector table plus randomized run against a seconds-level reference model.
// Exercises the night flash input as well when SLC_NIGHT_FLASH_EN is defined.
module tb_slc_phase_timer;

  localparam int NS_T = 12;
  localparam int EW_T = 10;
  localparam int Y_T  = 3;
  localparam int TDIV = 4;
  localparam int SDIV = 2;

  logic       clk;
  logic       clr;
  logic       en;
  logic       night_in;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [1:0] phase;
  logic [3:0] bcd;
  logic [2:0] dig_sel;
  logic       blank_n;

  int checks = 0;
  int errors = 0;

  slc_phase_timer #(
    .NS_GREEN_T(NS_T),
    .EW_GREEN_T(EW_T),
    .YELLOW_T(Y_T),
    .TICK_DIV(TDIV),
    .SCAN_DIV(SDIV)
  ) dut (
    .clk(clk),
    .clr(clr),
    .en(en),
`ifdef SLC_NIGHT_FLASH_EN
    .night(night_in),
`endif
    .ns_light(ns_light),
    .ew_light(ew_light),
    .phase(phase),
    .bcd(bcd),
    .dig_sel(dig_sel),
    .blank_n(blank_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: seconds remaining as a plain integer, phase index, and elapsed cycle counts.
  int m_phase;
  int m_remain;
  int m_acc;
  int m_scan;
  bit m_flash;
  bit m_night_prev;
  int dur_tab[4] = '{NS_T, Y_T, EW_T, Y_T};
  logic [2:0] lamp_ns[4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] lamp_ew[4] = '{3'b100, 3'b100, 3'b001, 3'b010};

  task automatic model_step(input bit c, input bit e, input bit n);
    bit tick;
    if (c) begin
      m_phase = 0; m_remain = NS_T; m_acc = 0; m_scan = 0;
      m_flash = 0; m_night_prev = 0;
    end else begin
      m_scan++;
      if (m_night_prev && !n) begin
        m_phase = 0; m_remain = NS_T; m_acc = 0; m_flash = 0;
      end else begin
        tick = 0;
        if (e || n) begin
          m_acc++;
          if (m_acc == TDIV) begin
            m_acc = 0;
            tick = 1;
          end
        end
        if (tick) begin
          if (n) m_flash = !m_flash;
          else if (m_remain == 1) begin
            m_phase  = (m_phase + 1) % 4;
            m_remain = dur_tab[m_phase];
          end else m_remain--;
        end
      end
      m_night_prev = n;
    end
  endtask

  function automatic logic [15:0] pack(input logic [1:0] ph, input logic [2:0] ns, input logic [2:0] ew,
                                       input logic [3:0] b, input logic [2:0] sel, input logic bl);
    return {ph, ns, ew, b, sel, bl};
  endfunction

  function automatic logic [15:0] model_expect(input bit n);
    int dig;
    logic [3:0] shown;
    logic bl;
    dig   = (m_scan / SDIV) % 2;
    shown = (dig == 1) ? 4'(m_remain / 10) : 4'(m_remain % 10);
    bl    = !(dig == 1 && (m_remain / 10) == 0);
    if (n)
      return pack(2'(m_phase), {1'b0, m_flash, 1'b0}, {1'b0, m_flash, 1'b0}, shown, 3'(dig), 1'b0);
    return pack(2'(m_phase), lamp_ns[m_phase], lamp_ew[m_phase], shown, 3'(dig), bl);
  endfunction

  task automatic applyStimulus(input bit c, input bit e, input bit n);
    clr = c; en = e; night_in = n;
    @(posedge clk);
    model_step(c, e, n);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] want);
    logic [15:0] got;
    got = pack(phase, ns_light, ew_light, bcd, dig_sel, blank_n);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got phase=%0d ns=%b ew=%b bcd=%0d sel=%0d blank_n=%b, want phase=%0d ns=%b ew=%b bcd=%0d sel=%0d blank_n=%b",
               name, got[15:14], got[13:11], got[10:8], got[7:4], got[3:1], got[0],
               want[15:14], want[13:11], want[10:8], want[7:4], want[3:1], want[0]);
    end
  endtask

  typedef struct {
    bit         c;
    bit         e;
    int         ncyc;
    logic [1:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [3:0] b;
    logic [2:0] sel;
    logic       bl;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit c, input bit e, input int ncyc, input logic [1:0] ph,
                         input logic [2:0] ns, input logic [2:0] ew, input logic [3:0] b,
                         input logic [2:0] sel, input logic bl);
    vec_t v;
    v.c = c; v.e = e; v.ncyc = ncyc; v.ph = ph; v.ns = ns; v.ew = ew;
    v.b = b; v.sel = sel; v.bl = bl;
    vecs.push_back(v);
  endtask

  initial begin
    bit rc, re, rn;
    bit night_run;
    vec_t v;

    // Cumulative cycle count since clr release noted per row; digit = (k/2)%2, ticks every 4 cycles.
    add_vec(1, 1,  2, 0, 3'b001, 3'b100, 2, 0, 1); // reset, count 12
    add_vec(0, 1,  4, 0, 3'b001, 3'b100, 1, 0, 1); // k=4   11
    add_vec(0, 1,  2, 0, 3'b001, 3'b100, 1, 1, 1); // k=6   11 tens
    add_vec(0, 1,  2, 0, 3'b001, 3'b100, 0, 0, 1); // k=8   10
    add_vec(0, 1,  2, 0, 3'b001, 3'b100, 1, 1, 1); // k=10  10 tens
    add_vec(0, 1,  2, 0, 3'b001, 3'b100, 9, 0, 1); // k=12  09
    add_vec(0, 1,  2, 0, 3'b001, 3'b100, 0, 1, 0); // k=14  09 tens blanked
    add_vec(0, 1, 34, 1, 3'b010, 3'b100, 3, 0, 1); // k=48  phase 1, 03
    add_vec(0, 1,  2, 1, 3'b010, 3'b100, 0, 1, 0); // k=50
    add_vec(0, 1, 10, 2, 3'b100, 3'b001, 0, 0, 1); // k=60  phase 2, 10
    add_vec(0, 1,  2, 2, 3'b100, 3'b001, 1, 1, 1); // k=62
    add_vec(0, 1, 38, 3, 3'b100, 3'b010, 3, 0, 1); // k=100 phase 3, 03
    add_vec(0, 1, 12, 0, 3'b001, 3'b100, 2, 0, 1); // k=112 phase 0, 12
    add_vec(0, 1,  2, 0, 3'b001, 3'b100, 1, 1, 1); // k=114
    add_vec(0, 1, 18, 0, 3'b001, 3'b100, 7, 0, 1); // k=132 07
    add_vec(0, 0,  8, 0, 3'b001, 3'b100, 7, 0, 1); // paused
    add_vec(0, 0,  2, 0, 3'b001, 3'b100, 0, 1, 0); // paused, scan still toggles
    add_vec(0, 1,  3, 0, 3'b001, 3'b100, 7, 0, 1); // resumed, tick not yet due
    add_vec(0, 1,  3, 0, 3'b001, 3'b100, 6, 0, 1); // k=148 06
    add_vec(0, 1,  4, 0, 3'b001, 3'b100, 5, 0, 1); // k=152 05
    add_vec(0, 1, 52, 2, 3'b100, 3'b001, 5, 0, 1); // k=204 phase 2, 05
    add_vec(1, 1,  1, 0, 3'b001, 3'b100, 2, 0, 1); // mid-op clr
    add_vec(0, 1,  3, 0, 3'b001, 3'b100, 1, 1, 1); // k=3 12 tens
    add_vec(0, 1,  1, 0, 3'b001, 3'b100, 1, 0, 1); // k=4 11

    clr = 1'b1; en = 1'b1; night_in = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      for (int c = 0; c < v.ncyc; c++) applyStimulus(v.c, v.e, 1'b0);
      checkOutput($sformatf("vec%0d", i), pack(v.ph, v.ns, v.ew, v.b, v.sel, v.bl));
    end

`ifdef SLC_NIGHT_FLASH_EN
    // Night mode entry mid-phase, a few flash periods, then exit reload.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("night_on", model_expect(1'b1));
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("night_exit", pack(2'd0, 3'b001, 3'b100, 4'(m_scan / SDIV % 2 == 1 ? 1 : 2),
                                   3'(m_scan / SDIV % 2), 1'b1));
`endif

    night_run = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rc = ($urandom_range(199, 0) == 0);
      re = ($urandom_range(9, 0) != 0);
`ifdef SLC_NIGHT_FLASH_EN
      if ($urandom_range(119, 0) == 0) night_run = !night_run;
`endif
      rn = night_run;
      applyStimulus(rc, re, rn);
      checkOutput("random", model_expect(rn));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
